dmem_arbiter: RTL and testbench

Two-port arbiter and initialisation sequencer for the single-port byte-addressed data memory. After reset it sweeps memory and writes a fill word to every word location. It then shares the memory port between requester 0 (CPU load/store path) and requester 1 (loader/debug port). Arbitration is round-robin, with one outstanding transaction per requester and a req/ack handshake.

---
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: fills data memory with INIT_WORD after reset, then shares the single
// memory port between two req/ack requesters with round-robin arbitration.
module dmem_arbiter #(
  parameter int unsigned DEPTH_BYTES = 256,
  parameter logic [31:0] INIT_WORD   = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_req,
  output logic        init_done,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);
  localparam int unsigned WORDS = DEPTH_BYTES / 4;
  localparam int unsigned CW = WORDS > 1 ? $clog2(WORDS) : 1;
  typedef enum logic [1:0] {INIT, IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic init_done_q, init_done_d, last_q, last_d, win_q, win_d, we_q, we_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic mem_we_d, mem_re_d, bad;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    init_done_d = init_done_q;
    last_d = last_q;
    win_d = win_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    err_d = err_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    mem_we_d = 1'b0;
    mem_re_d = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    bad = addr_q[1:0] != 2'b00 || addr_q > 32'(DEPTH_BYTES - 4);
    case (state_q)
      INIT: begin
        mem_we_d = 1'b1;
        mem_addr_d = 32'(cnt_q) << 2;
        mem_wdata_d = INIT_WORD;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WORDS - 1)) begin
          state_d = IDLE;
          init_done_d = 1'b1;
          cnt_d = '0;
        end
      end
      IDLE: begin
        if (init_req) begin
          state_d = INIT;
          init_done_d = 1'b0;
          cnt_d = '0;
        end else if (m0_req || m1_req) begin
          win_d = (m0_req && m1_req) ? ~last_q : m1_req;
          we_d = win_d ? m1_we : m0_we;
          addr_d = win_d ? m1_addr : m0_addr;
          wdata_d = win_d ? m1_wdata : m0_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        err_d = bad;
        state_d = RESP;
        if (bad) begin
          rdata0_d = win_q ? rdata0_q : '0;
          rdata1_d = win_q ? '0 : rdata1_q;
        end else begin
          mem_addr_d = addr_q;
          mem_we_d = we_q;
          mem_re_d = !we_q;
          mem_wdata_d = we_q ? wdata_q : mem_wdata_q;
          rdata0_d = (!we_q && !win_q) ? mem_rdata : rdata0_q;
          rdata1_d = (!we_q && win_q) ? mem_rdata : rdata1_q;
        end
      end
      default: begin
        last_d = win_q;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q <= '0;
      init_done_q <= 1'b0;
      last_q <= 1'b1;
      win_q <= 1'b0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      init_done_q <= init_done_d;
      last_q <= last_d;
      win_q <= win_d;
      we_q <= we_d;
      err_q <= err_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
  // Reset state is INIT, so strobes and fill data are masked while rst_n is low.
  assign mem_we = rst_n & mem_we_d;
  assign mem_re = rst_n & mem_re_d;
  assign mem_addr = mem_addr_d;
  assign mem_wdata = rst_n ? mem_wdata_d : '0;
  assign init_done = init_done_q;
  assign m0_ack = state_q == RESP && !win_q;
  assign m1_ack = state_q == RESP && win_q;
  assign m0_err = m0_ack & err_q;
  assign m1_err = m1_ack & err_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table vectors, corner-case sequences and random traffic against a
// word-array memory model and per-port rdata model.
module tb_dmem_arbiter;
  localparam logic [31:0] IW = 32'h0000_0001;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic init_req = 1'b0;
  logic init_done;
  logic m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic m0_ack, m0_err, m1_ack, m1_err, mem_we, mem_re;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [64];
  logic [31:0] shadow [64];
  logic [31:0] prev_rd [2];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .init_done(init_done),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_fill();
    for (int i = 0; i < 64; i++) shadow[i] = IW;
  endtask

  task automatic chk_reset(input string t);
    chk({t, " init_done"}, 32'(init_done), 0);
    chk({t, " mem_we"}, 32'(mem_we), 0);
    chk({t, " mem_re"}, 32'(mem_re), 0);
    chk({t, " mem_addr"}, mem_addr, 0);
    chk({t, " mem_wdata"}, mem_wdata, 0);
    chk({t, " acks"}, {30'd0, m0_ack, m1_ack}, 0);
    chk({t, " errs"}, {30'd0, m0_err, m1_err}, 0);
    chk({t, " m0_rdata"}, m0_rdata, 0);
    chk({t, " m1_rdata"}, m1_rdata, 0);
    prev_rd[0] = '0;
    prev_rd[1] = '0;
  endtask

  task automatic wait_init(input string t);
    int n = 0;
    bit a_ok = 1'b1, d_ok = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (init_done) break;
      if (mem_we) begin
        if (mem_addr !== 32'(n * 4)) a_ok = 1'b0;
        if (mem_wdata !== IW || mem_re) d_ok = 1'b0;
        n++;
      end
    end
    chk({t, " sweep writes"}, 32'(n), 64);
    chk({t, " sweep addr order"}, 32'(a_ok), 1);
    chk({t, " sweep data"}, 32'(d_ok), 1);
    chk({t, " init_done"}, 32'(init_done), 1);
    model_fill();
  endtask

  task automatic xact(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd, output logic er,
                      output bit oth, output bit stb, output bit hi);
    lat = -1; rd = '0; er = 1'b0; oth = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    if (p) begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; end
    else begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; end
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clk);
      if (mem_we || mem_re) stb = 1'b1;
      if (p ? m0_ack : m1_ack) oth = 1'b1;
      if (p ? m1_ack : m0_ack) begin
        lat = i;
        rd = p ? m1_rdata : m0_rdata;
        er = p ? m1_err : m0_err;
      end
    end
    @(posedge clk); #1;
    m0_req = 0; m1_req = 0;
    @(negedge clk);
    hi = p ? m1_ack : m0_ack;
  endtask

  task automatic run(input string nm, input bit p, input bit we, input logic [31:0] a,
                     input logic [31:0] d, input bit e, input logic [31:0] rd);
    int lat;
    logic [31:0] g;
    logic ge;
    bit oth, stb, hi;
    xact(p, we, a, d, lat, g, ge, oth, stb, hi);
    chk({nm, " latency"}, 32'(lat), 2);
    chk({nm, " err"}, 32'(ge), 32'(e));
    chk({nm, " rdata"}, g, rd);
    chk({nm, " other ack"}, 32'(oth), 0);
    chk({nm, " ack width"}, 32'(hi), 0);
    if (e) chk({nm, " strobe"}, 32'(stb), 0);
    if (!e && we) shadow[a[7:2]] = d;
    prev_rd[p] = e ? 32'h0 : (we ? prev_rd[p] : shadow[a[7:2]]);
  endtask

  typedef struct {
    string nm; bit p; bit we; logic [31:0] a; logic [31:0] d; bit e; logic [31:0] rd;
  } vec_t;
  vec_t tbl [10];

  initial begin
    int k, pos[4];
    bit ord[4];
    bit both;
    int writes;
    logic [31:0] rd1;
    tbl[0] = '{"m1 wr 20", 1, 1, 32'h20, 32'hDEADBEEF, 0, 32'h1};
    tbl[1] = '{"m0 rd 20", 0, 0, 32'h20, 32'h0, 0, 32'hDEADBEEF};
    tbl[2] = '{"m0 rd 22", 0, 0, 32'h22, 32'h0, 1, 32'h0};
    tbl[3] = '{"m1 rd 100", 1, 0, 32'h100, 32'h0, 1, 32'h0};
    tbl[4] = '{"m0 rd 10", 0, 0, 32'h10, 32'h0, 0, 32'h1};
    tbl[5] = '{"m0 wr fc", 0, 1, 32'hFC, 32'hCAFEF00D, 0, 32'h1};
    tbl[6] = '{"m1 rd fc", 1, 0, 32'hFC, 32'h0, 0, 32'hCAFEF00D};
    tbl[7] = '{"m1 wr 7f", 1, 1, 32'h7F, 32'h55, 1, 32'h0};
    tbl[8] = '{"m0 rd 00", 0, 0, 32'h0, 32'h0, 0, 32'h1};
    tbl[9] = '{"m1 rd fffffffc", 1, 0, 32'hFFFFFFFC, 32'h0, 1, 32'h0};
    #1 rst_n = 0;
    #2 chk_reset("por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    wait_init("por");

    // both requesters held high: grants alternate starting with m0, 3 cycles apart
    @(posedge clk); #1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    m1_req = 1; m1_we = 0; m1_addr = 32'h14;
    k = 0; both = 0;
    for (int i = 0; i < 40 && k < 4; i++) begin
      @(negedge clk);
      if (m0_ack && m1_ack) both = 1;
      if (m0_ack || m1_ack) begin ord[k] = m1_ack; pos[k] = i; k++; end
    end
    @(posedge clk); #1;
    m0_req = 0; m1_req = 0;
    chk("tie ack count", 32'(k), 4);
    chk("tie double ack", 32'(both), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tie grant %0d", i), 32'(ord[i]), 32'(i % 2));
      chk($sformatf("tie ack slot %0d", i), 32'(pos[i]), 32'(2 + 3 * i));
    end
    chk("tie m0 rdata", m0_rdata, IW);
    chk("tie m1 rdata", m1_rdata, IW);
    prev_rd[0] = IW;
    prev_rd[1] = IW;

    for (int i = 0; i < 10; i++)
      run(tbl[i].nm, tbl[i].p, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].e, tbl[i].rd);

    // init_req beats a simultaneous m1 request; m1 is served after the sweep
    run("m0 wr 40", 0, 1, 32'h40, 32'h12345678, 0, 32'h1);
    @(posedge clk); #1;
    init_req = 1; m1_req = 1; m1_we = 0; m1_addr = 32'h40;
    @(posedge clk); #1;
    init_req = 0;
    writes = 0; k = 0; rd1 = '0;
    for (int i = 0; i < 300 && k == 0; i++) begin
      @(negedge clk);
      if (i == 0) chk("reinit init_done low", 32'(init_done), 0);
      if (mem_we) writes++;
      if (m1_ack) begin k = 1; rd1 = m1_rdata; end
    end
    @(posedge clk); #1;
    m1_req = 0;
    chk("reinit m1 acked", 32'(k), 1);
    chk("reinit sweep before ack", 32'(writes), 64);
    chk("reinit m1 rdata", rd1, IW);
    chk("reinit init_done", 32'(init_done), 1);
    model_fill();
    prev_rd[1] = IW;

    for (int i = 0; i < 40; i++) begin
      bit p, we, e;
      int r;
      logic [31:0] a, d, rd;
      p = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      d = $urandom;
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 63)) * 4;
      if (r == 7) a = a + 32'($urandom_range(1, 3));
      else if (r == 8) a = a + 32'h100;
      else if (r == 9) a = 32'hFFFF_FFFC;
      e = (a % 4 != 0) || (a > 252);
      rd = e ? 32'h0 : (we ? prev_rd[p] : shadow[a / 4]);
      run($sformatf("rnd%0d", i), p, we, a, d, e, rd);
    end

    // reset during m0's ACCESS cycle aborts it and restarts the sweep
    @(posedge clk); #1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    @(negedge clk);
    @(negedge clk);
    chk("abort access mem_re", 32'(mem_re), 1);
    rst_n = 0;
    #1 chk_reset("abort");
    m0_req = 0;
    repeat (2) begin
      @(negedge clk);
      chk("abort no ack", 32'(m0_ack), 0);
    end
    @(posedge clk); #1;
    rst_n = 1;
    wait_init("abort");
    run("post abort m0 rd 10", 0, 0, 32'h10, 32'h0, 0, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
